// File: rtl/lif_neuron_grid.sv
// LAYERS x WIDTH grid of leaky integrate-and-fire neurons with 3-tap nearest-neighbour
// connectivity between layers, configured through a single serial shift chain.
module lif_neuron_grid #(
  parameter int WIDTH    = 8,
  parameter int LAYERS   = 3,
  parameter int WEIGHT_W = 4,
  parameter int THR_W    = 6,
  parameter int ACC_W    = 8,
  parameter int REFRAC   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic [WIDTH-1:0] spike_in,
  input  logic             cfg_en,
  input  logic             cfg_data,
  output logic             cfg_out,
  output logic [WIDTH-1:0] spike_out,
  output logic             spike_valid
);

  localparam int CFG_W = 3*WEIGHT_W + THR_W + 2;
  localparam int N     = LAYERS*WIDTH;
  localparam int CHAIN = N*CFG_W;
  localparam int REF_W = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
  localparam int EXT_W = ACC_W + 2;

  localparam logic signed [EXT_W-1:0] V_MAX = EXT_W'((2**(ACC_W-1)) - 1);
  localparam logic signed [EXT_W-1:0] V_MIN = EXT_W'(-(2**(ACC_W-1)));

  logic [CHAIN-1:0]     chain_q, chain_d;
  logic [N*ACC_W-1:0]   v_q, v_d, nv;
  logic [N*REF_W-1:0]   ref_q, ref_d, nref;
  logic [N-1:0]         spk_q, spk_d, nspk;
  logic                 spike_valid_q, spike_valid_d;

  genvar gl, gc;
  generate
    for (gl = 0; gl < LAYERS; gl++) begin : g_layer
      logic [WIDTH-1:0] src;
      if (gl == 0) begin : g_src_in
        assign src = spike_in;
      end else begin : g_src_prev
        assign src = spk_q[(gl-1)*WIDTH +: WIDTH];
      end

      for (gc = 0; gc < WIDTH; gc++) begin : g_col
        localparam int NI = gl*WIDTH + gc;

        logic [CFG_W-1:0]           cfg;
        logic signed [WEIGHT_W-1:0] w_l, w_c, w_r;
        logic [THR_W-1:0]           thr;
        logic [1:0]                 leak;
        logic                       tap_l, tap_c, tap_r;
        logic signed [EXT_W-1:0]    sum, v_ext, v_raw;
        logic signed [ACC_W-1:0]    v_cur, v_sat, thr_ext;
        logic [REF_W-1:0]           ref_cur;
        logic                       in_ref, fire;

        assign cfg  = chain_q[NI*CFG_W +: CFG_W];
        assign w_l  = cfg[0 +: WEIGHT_W];
        assign w_c  = cfg[WEIGHT_W +: WEIGHT_W];
        assign w_r  = cfg[2*WEIGHT_W +: WEIGHT_W];
        assign thr  = cfg[3*WEIGHT_W +: THR_W];
        assign leak = cfg[3*WEIGHT_W + THR_W +: 2];

        // Edge columns have no neighbour on the outer side; no wrap-around.
        if (gc == 0) begin : g_no_left
          assign tap_l = 1'b0;
        end else begin : g_left
          assign tap_l = src[gc-1];
        end
        if (gc == WIDTH-1) begin : g_no_right
          assign tap_r = 1'b0;
        end else begin : g_right
          assign tap_r = src[gc+1];
        end
        assign tap_c = src[gc];

        assign sum = (tap_l ? EXT_W'(w_l) : {EXT_W{1'b0}})
                   + (tap_c ? EXT_W'(w_c) : {EXT_W{1'b0}})
                   + (tap_r ? EXT_W'(w_r) : {EXT_W{1'b0}});

        assign v_cur   = v_q[NI*ACC_W +: ACC_W];
        assign ref_cur = ref_q[NI*REF_W +: REF_W];
        assign v_ext   = EXT_W'(v_cur);
        // leak = 0 subtracts all of v, so the neuron keeps no memory.
        assign v_raw   = v_ext - (v_ext >>> leak) + sum;
        assign v_sat   = (v_raw > V_MAX) ? V_MAX[ACC_W-1:0] :
                         (v_raw < V_MIN) ? V_MIN[ACC_W-1:0] : v_raw[ACC_W-1:0];
        assign thr_ext = ACC_W'(thr);

        assign in_ref = (ref_cur != '0);
        assign fire   = (thr != '0) && (v_sat >= thr_ext);

        assign nspk[NI]                = !in_ref && fire;
        assign nv[NI*ACC_W +: ACC_W]   = (in_ref || fire) ? '0 : v_sat;
        assign nref[NI*REF_W +: REF_W] = in_ref ? (ref_cur - REF_W'(1)) :
                                         (fire ? REF_W'(REFRAC) : '0);
      end
    end
  endgenerate

  // Configuration shifting has priority over a time-step and clears all dynamics.
  always_comb begin
    chain_d       = chain_q;
    v_d           = v_q;
    ref_d         = ref_q;
    spk_d         = spk_q;
    spike_valid_d = 1'b0;
    if (cfg_en) begin
      chain_d = {cfg_data, chain_q[CHAIN-1:1]};
      v_d     = '0;
      ref_d   = '0;
      spk_d   = '0;
    end else if (tick) begin
      v_d           = nv;
      ref_d         = nref;
      spk_d         = nspk;
      spike_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q       <= '0;
      v_q           <= '0;
      ref_q         <= '0;
      spk_q         <= '0;
      spike_valid_q <= 1'b0;
    end else begin
      chain_q       <= chain_d;
      v_q           <= v_d;
      ref_q         <= ref_d;
      spk_q         <= spk_d;
      spike_valid_q <= spike_valid_d;
    end
  end

  assign cfg_out     = chain_q[0];
  assign spike_out   = spk_q[N-1 -: WIDTH];
  assign spike_valid = spike_valid_q;

endmodule

// File: tb/tb_lif_neuron_grid.sv
// Directed plus randomized bench for lif_neuron_grid, checked against an integer-arithmetic
// reference model of the whole network that decodes its own copy of the config chain.
module tb_lif_neuron_grid;

  localparam int WIDTH    = 8;
  localparam int LAYERS   = 3;
  localparam int WEIGHT_W = 4;
  localparam int THR_W    = 6;
  localparam int ACC_W    = 8;
  localparam int REFRAC   = 2;
  localparam int CFG_W    = 3*WEIGHT_W + THR_W + 2;
  localparam int N        = LAYERS*WIDTH;
  localparam int CHAIN    = N*CFG_W;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             tick = 1'b0;
  logic [WIDTH-1:0] spike_in = '0;
  logic             cfg_en = 1'b0;
  logic             cfg_data = 1'b0;
  logic             cfg_out;
  logic [WIDTH-1:0] spike_out;
  logic             spike_valid;

  lif_neuron_grid #(
    .WIDTH(WIDTH), .LAYERS(LAYERS), .WEIGHT_W(WEIGHT_W),
    .THR_W(THR_W), .ACC_W(ACC_W), .REFRAC(REFRAC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .spike_in(spike_in),
    .cfg_en(cfg_en), .cfg_data(cfg_data), .cfg_out(cfg_out),
    .spike_out(spike_out), .spike_valid(spike_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [CHAIN-1:0] tb_chain;
  logic [CHAIN-1:0] img;
  logic [CHAIN-1:0] pat_a;
  int  mv   [LAYERS][WIDTH];
  int  mref [LAYERS][WIDTH];
  bit  mspk [LAYERS][WIDTH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int field(input int n, input int off, input int w, input bit sgn);
    int r = 0;
    for (int j = 0; j < w; j++) r |= int'(tb_chain[n*CFG_W + off + j]) << j;
    if (sgn && tb_chain[n*CFG_W + off + w - 1]) r -= (1 << w);
    return r;
  endfunction

  task automatic model_clear();
    for (int l = 0; l < LAYERS; l++)
      for (int c = 0; c < WIDTH; c++) begin
        mv[l][c] = 0; mref[l][c] = 0; mspk[l][c] = 0;
      end
  endtask

  task automatic model_tick(input logic [WIDTH-1:0] sin);
    bit prev [LAYERS][WIDTH];
    prev = mspk;
    for (int l = 0; l < LAYERS; l++) begin
      for (int c = 0; c < WIDTH; c++) begin
        int n, sum, vp, thr, leak, cc;
        bit s;
        n = l*WIDTH + c;
        sum = 0;
        for (int d = -1; d <= 1; d++) begin
          cc = c + d;
          if (cc >= 0 && cc < WIDTH) begin
            s = (l == 0) ? sin[cc] : prev[l-1][cc];
            if (s) sum += field(n, (d+1)*WEIGHT_W, WEIGHT_W, 1'b1);
          end
        end
        if (mref[l][c] > 0) begin
          mref[l][c]--; mv[l][c] = 0; mspk[l][c] = 0;
        end else begin
          thr  = field(n, 3*WEIGHT_W, THR_W, 1'b0);
          leak = field(n, 3*WEIGHT_W + THR_W, 2, 1'b0);
          vp = mv[l][c] - (mv[l][c] >>> leak) + sum;
          if (vp > 127) vp = 127;
          if (vp < -128) vp = -128;
          if (thr != 0 && vp >= thr) begin
            mspk[l][c] = 1; mv[l][c] = 0; mref[l][c] = REFRAC;
          end else begin
            mspk[l][c] = 0; mv[l][c] = vp;
          end
        end
      end
    end
  endtask

  function automatic logic [WIDTH-1:0] model_out();
    logic [WIDTH-1:0] r;
    for (int c = 0; c < WIDTH; c++) r[c] = mspk[LAYERS-1][c];
    return r;
  endfunction

  task automatic shift(input logic d);
    cfg_en = 1'b1; cfg_data = d;
    @(posedge clk); #1;
    cfg_en = 1'b0;
    tb_chain = {d, tb_chain[CHAIN-1:1]};
    model_clear();
  endtask

  task automatic load(input logic [CHAIN-1:0] c);
    for (int i = 0; i < CHAIN; i++) shift(c[i]);
  endtask

  task automatic set_neuron(input int n, input int wl, input int wc, input int wr,
                            input int thr, input int leak);
    logic [31:0] t;
    t = wl;   img[n*CFG_W +: WEIGHT_W] = t[WEIGHT_W-1:0];
    t = wc;   img[n*CFG_W + WEIGHT_W +: WEIGHT_W] = t[WEIGHT_W-1:0];
    t = wr;   img[n*CFG_W + 2*WEIGHT_W +: WEIGHT_W] = t[WEIGHT_W-1:0];
    t = thr;  img[n*CFG_W + 3*WEIGHT_W +: THR_W] = t[THR_W-1:0];
    t = leak; img[n*CFG_W + 3*WEIGHT_W + THR_W +: 2] = t[1:0];
  endtask

  task automatic relay_img();
    for (int n = 0; n < N; n++) set_neuron(n, 0, 1, 0, 1, 0);
  endtask

  task automatic do_tick(input logic [WIDTH-1:0] s, input int idle);
    spike_in = s; tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
    model_tick(s);
    $display("tick spike_in=%02h spike_out=%02h valid=%0b", s, spike_out, spike_valid);
    chk("valid_pulse", spike_valid, 1);
    chk("spike_out", spike_out, model_out());
    for (int i = 0; i < idle; i++) begin
      @(posedge clk); #1;
      chk("valid_idle", spike_valid, 0);
      chk("hold_out", spike_out, model_out());
    end
  endtask

  initial begin
    tb_chain = '0;
    img = '0;
    model_clear();

    // Reset state
    #12;
    chk("rst_spike_out", spike_out, 0);
    chk("rst_valid", spike_valid, 0);
    chk("rst_cfg_out", cfg_out, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Config readback: second pass replays the first pattern on cfg_out
    for (int i = 0; i < CHAIN; i++) pat_a[i] = 1'($urandom);
    load(pat_a);
    relay_img();
    for (int i = 0; i < CHAIN; i++) begin
      chk("readback", cfg_out, pat_a[i]);
      shift(img[i]);
    end
    $display("readback of %0d bits done", CHAIN);

    // Relay latency
    do_tick(8'h81, 1); chk("relay_t1", spike_out, 8'h00);
    do_tick(8'h81, 1); chk("relay_t2", spike_out, 8'h00);
    do_tick(8'h81, 1); chk("relay_t3", spike_out, 8'h81);
    repeat (4) do_tick(WIDTH'($urandom), 1);

    // Integrate with leak 1 then leak 2 on layer-0 column 0
    relay_img(); set_neuron(0, 0, 2, 0, 5, 1); load(img);
    repeat (8) do_tick(8'h01, 1);
    relay_img(); set_neuron(0, 0, 2, 0, 5, 2); load(img);
    repeat (8) do_tick(8'h01, 1);

    // Large drive with refractory period
    relay_img(); set_neuron(1, 7, 7, 7, 63, 3); load(img);
    repeat (16) do_tick(8'h07, 1);

    // Negative saturation: a wrapping accumulator would fire spuriously
    relay_img(); set_neuron(1, -8, -8, -8, 63, 3); load(img);
    for (int i = 0; i < 20; i++) begin
      do_tick(8'h07, 1);
      chk("sat_no_wrap", spike_out[1], 0);
    end

    // No wrap at the edge: col 0 left tap sees nothing from col WIDTH-1
    relay_img(); set_neuron(0, 7, 0, 0, 1, 0); load(img);
    for (int i = 0; i < 3; i++) begin
      do_tick(8'h80, 1);
      chk("edge_no_wrap", spike_out[0], 0);
    end
    chk("edge_far_col", spike_out[7], 1);

    // tick together with cfg_en: shift wins, no valid pulse
    do_tick(8'hFF, 0);
    spike_in = 8'hFF; tick = 1'b1; cfg_en = 1'b1; cfg_data = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0; cfg_en = 1'b0;
    tb_chain = {1'b1, tb_chain[CHAIN-1:1]};
    model_clear();
    chk("prio_no_valid", spike_valid, 0);
    chk("prio_shift_once", cfg_out, tb_chain[0]);
    chk("prio_state_clr", spike_out, 0);
    repeat (4) do_tick(WIDTH'($urandom), 1);

    // Randomized configurations and traffic
    repeat (6) begin
      for (int i = 0; i < CHAIN; i++) img[i] = 1'($urandom);
      load(img);
      repeat (20) do_tick(WIDTH'($urandom), $urandom_range(1, 3));
    end

    // Asynchronous reset mid-run
    relay_img(); set_neuron(0, 1, 1, 0, 1, 0); load(img);
    do_tick(8'h81, 1); do_tick(8'h81, 1); do_tick(8'h81, 0);
    chk("pre_rst_out", spike_out, 8'h81);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out", spike_out, 0);
    chk("async_rst_valid", spike_valid, 0);
    chk("async_rst_cfg", cfg_out, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tb_chain = '0;
    model_clear();
    repeat (4) do_tick(8'hFF, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
